lm32_trace_buf: RTL

Synthesizable retired-instruction trace buffer for the LM32 core, the hardware successor to simulation-only tracing. It tracks the decoded instruction word alongside the pipeline from D to W, and on every retired, non-killed instruction it writes {PC, instruction} into a circular on-chip buffer of parametrised depth. Capture runs in fill-once or wrap-until-trigger mode with a programmable post-trigger count. Software or a debug bridge reads the buffer back oldest-first through a registered read port.

---
 rtl/lm32_trace_buf.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lm32_trace_buf.sv
// Retired-instruction trace buffer for LM32: follows the instruction word from D to W
// and records {pc, instruction} of every retired, non-killed instruction into a circular RAM.
module lm32_trace_buf #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_x,
  input  logic                  stall_m,
  input  logic                  valid_w,
  input  logic                  kill_w,
  input  logic [31:0]           instruction_d,
  input  logic [29:0]           pc_w,
  input  logic [1:0]            mode_i,
  input  logic                  arm_i,
  input  logic                  trig_en_i,
  input  logic [29:0]           trig_pc_i,
  input  logic [ADDR_WIDTH-1:0] post_cnt_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [61:0]           rd_data_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  wrapped_o,
  output logic                  triggered_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FULL_M1 = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
  localparam logic [1:0]            MODE_FILL = 2'd1;
  localparam logic [1:0]            MODE_WRAP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_POST,
    ST_DONE
  } state_e;

  state_e                state_q;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,     count_d;
  logic                  wrapped_q,   wrapped_d;
  logic [ADDR_WIDTH-1:0] post_left_q, post_left_d;
  logic                  triggered_q;
  logic                  busy_q;
  logic                  done_q;

  logic [31:0] instruction_x_q;
  logic [31:0] instruction_m_q;
  logic [31:0] instruction_w_q;

  logic [61:0]           mem [DEPTH];
  logic [61:0]           rd_data_q;
  logic [ADDR_WIDTH-1:0] rd_phys;

  logic ret;
  logic capturing;
  logic mem_we;
  logic trig_hit;

  // Instruction word shadows the pipeline so it lines up with pc_w at W.
  // NOTE: sequential state uses <= so every stage samples pre-edge values; blocking
  // assignments here would let instruction_d fall straight through to W in one edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instruction_x_q <= '0;
      instruction_m_q <= '0;
      instruction_w_q <= '0;
    end else begin
      if (!stall_x) instruction_x_q <= instruction_d;
      if (!stall_m) instruction_m_q <= instruction_x_q;
      instruction_w_q <= instruction_m_q;
    end
  end

  assign ret       = valid_w & ~kill_w;
  assign capturing = (state_q == ST_RUN) || (state_q == ST_POST);
  assign mem_we    = ret & capturing & ~arm_i & ~rst_i;
  assign trig_hit  = trig_en_i && (pc_w == trig_pc_i);

  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + ONE;
    count_d     = (count_q == FULL) ? count_q : count_q + 1'b1;
    wrapped_d   = wrapped_q | ((mode_q == MODE_WRAP) && (wr_ptr_q == PTR_MAX));
    post_left_d = post_left_q - ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
      post_left_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (arm_i) begin
      mode_q      <= mode_i;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
      post_left_q <= post_cnt_i;
      done_q      <= 1'b0;
      if (mode_i == MODE_FILL || mode_i == MODE_WRAP) begin
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
      end else begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end
    end else if (ret && capturing) begin
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      case (state_q)
        ST_RUN: begin
          if (mode_q == MODE_FILL) begin
            if (count_q == FULL_M1) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (trig_hit) begin
            triggered_q <= 1'b1;
            if (post_left_q == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_POST;
            end
          end
        end
        ST_POST: begin
          post_left_q <= post_left_d;
          if (post_left_q == ONE) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the trace RAM is deliberately left out of reset so it maps onto block RAM;
  // only pointers and flags define which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_ptr_q] <= {pc_w, instruction_w_q};
  end

  // Once wrapped, the oldest entry sits at the write pointer.
  assign rd_phys = (wrapped_q ? wr_ptr_q : '0) + rd_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= mem[rd_phys];
  end

  assign rd_data_o   = rd_data_q;
  assign count_o     = count_q;
  assign wrapped_o   = wrapped_q;
  assign triggered_o = triggered_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
